// File: rtl/even_seq_monitor.sv
// Monitors a 4-bit even counter {a,b,c,d} for correct +2 (mod 16) stepping, reports lock,
// sticky fault with the offending sample, and a saturating count of clean 14->0 wraps.
//
// state | meaning
// SYNC  | waiting for an even sample to use as the reference
// TRACK | following the sequence, counting correct steps toward lock
// LOCK  | LOCK_LEN consecutive correct steps seen, still following
// FAULT | sequence broken; holds until clr or reset
module even_seq_monitor #(
  parameter int LOCK_LEN = 8,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a,
  input  logic              b,
  input  logic              c,
  input  logic              d,
  input  logic              clr,
  output logic [3:0]        val,
  output logic              locked,
  output logic              err,
  output logic [3:0]        last_bad,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {SYNC, TRACK, LOCK, FAULT} state_t;

  localparam logic [7:0] LOCK_LEN_V = 8'(LOCK_LEN);

  state_t             state;
  logic [3:0]         prev;
  logic [7:0]         run;
  logic [3:0]         s;
  logic               step_ok;
  logic               wrap_hit;
  logic [7:0]         run_inc;
  logic [WRAP_W-1:0]  wrap_sat;

  assign s        = {a, b, c, d};
  // prev is always even, so an odd sample or a stalled value can never match
  assign step_ok  = (s == prev + 4'd2);
  assign wrap_hit = step_ok && (prev == 4'd14);
  assign run_inc  = run + 8'd1;
  assign wrap_sat = (wrap_cnt == '1) ? wrap_cnt : wrap_cnt + WRAP_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SYNC;
      prev     <= 4'd0;
      run      <= 8'd0;
      val      <= 4'd0;
      locked   <= 1'b0;
      err      <= 1'b0;
      last_bad <= 4'd0;
      wrap_cnt <= '0;
    end else begin
      val <= s;
      if (clr) begin
        state    <= SYNC;
        run      <= 8'd0;
        locked   <= 1'b0;
        err      <= 1'b0;
        last_bad <= 4'd0;
        wrap_cnt <= '0;
      end else begin
        case (state)
          SYNC: begin
            if (!s[0]) begin
              prev  <= s;
              run   <= 8'd0;
              state <= TRACK;
            end
          end
          TRACK: begin
            if (step_ok) begin
              prev <= s;
              run  <= run_inc;
              if (wrap_hit) wrap_cnt <= wrap_sat;
              if (run_inc == LOCK_LEN_V) begin
                state  <= LOCK;
                locked <= 1'b1;
              end
            end else begin
              state    <= FAULT;
              err      <= 1'b1;
              last_bad <= s;
            end
          end
          LOCK: begin
            if (step_ok) begin
              prev <= s;
              if (wrap_hit) wrap_cnt <= wrap_sat;
            end else begin
              state    <= FAULT;
              locked   <= 1'b0;
              err      <= 1'b1;
              last_bad <= s;
            end
          end
          FAULT: ;
          default: begin
            state  <= SYNC;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/even_seq_monitor.md
EVEN_SEQ_MONITOR -- requirements
Module: even_seq_monitor

Interface
REQ-001 Parameter LOCK_LEN, default 8, SHALL set the number of consecutive correct steps required to assert LOCKED (range 1..255).
REQ-002 Parameter WRAP_W, default 8, SHALL set the width of WRAP_CNT.
REQ-003 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 RST_N  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 A  input  1  count bit 3 (MSB) from the even counter.
REQ-006 B  input  1  count bit 2.
REQ-007 C  input  1  count bit 1.
REQ-008 D  input  1  count bit 0 (LSB).
REQ-009 CLR  input  1  synchronous clear of fault, lock and wrap count.
REQ-010 VAL  output  4  registered copy of the last sample {A,B,C,D}.
REQ-011 LOCKED  output  1  high while the sequence is tracked and locked.
REQ-012 ERR  output  1  sticky sequence-fault flag.
REQ-013 LAST_BAD  output  4  sample that caused the fault.
REQ-014 WRAP_CNT  output  WRAP_W  count of correct 14->0 wraps, saturating.

Function
REQ-015 Each rising CLK edge SHALL sample s={A,B,C,D} directly; VAL SHALL equal s one edge later.
REQ-016 The FSM SHALL have states SYNC, TRACK, LOCK and FAULT; "correct step" SHALL mean s == (prev+2) mod 16.
REQ-017 SYNC: if s[0]==0 then prev<=s, run<=0, go to TRACK; otherwise stay in SYNC with no other effect.
REQ-018 TRACK: on a correct step prev<=s and run<=run+1, going to LOCK when run+1 == LOCK_LEN; on an incorrect step go to FAULT.
REQ-019 LOCK: on a correct step prev<=s and stay in LOCK; on an incorrect step go to FAULT.
REQ-020 Entry to FAULT SHALL set ERR=1 and LAST_BAD<=s on the same edge; FAULT SHALL ignore all samples until CLR or reset.
REQ-021 LOCKED SHALL be 1 exactly while the state is LOCK.
REQ-022 WRAP_CNT SHALL increment on a correct step with prev==14 and s==0 while in TRACK or LOCK, and SHALL saturate at 2^WRAP_W-1.
REQ-023 An odd sample in TRACK or LOCK SHALL be treated as an incorrect step.
REQ-024 A repeated value (a stalled counter) SHALL be treated as an incorrect step.
REQ-025 CLR=1 at an edge SHALL have priority over every transition: state<=SYNC, ERR<=0, LAST_BAD<=0, WRAP_CNT<=0, run<=0; VAL SHALL still update.
REQ-026 The edge after CLR is released SHALL be evaluated as SYNC.

Reset
REQ-027 RST_N low SHALL immediately force state=SYNC, VAL=0, LOCKED=0, ERR=0, LAST_BAD=0, WRAP_CNT=0, prev=0 and run=0, independent of CLK.
REQ-028 Reset asserted mid-operation (including in LOCK or FAULT) SHALL discard all progress; the first edge after RST_N rises SHALL be processed in SYNC.

Verification
REQ-029 Reset release, then samples 0,2,4,...,14,0 on successive edges -> LOCKED=1 after the edge sampling the final 0 (9th sample, 8 correct steps); WRAP_CNT=1 on that same edge; ERR=0.
REQ-030 Locked, then sample 8 driven after 4 -> ERR=1, LAST_BAD=8, LOCKED=0 on that edge; further samples 10,12 -> outputs unchanged.
REQ-031 Samples 3,5,7 from reset, then 6,8 -> SYNC held during the odd samples; TRACK entered on 6; run=1 after 8; LOCKED=0; ERR=0.
REQ-032 WRAP_W=2, 5 full correct cycles -> WRAP_CNT reads 1,2,3,3,3 after successive wraps.
REQ-033 In FAULT, CLR pulsed with sample 2, then 4 -> on the CLR edge ERR=0, LAST_BAD=0, WRAP_CNT=0; on the next edge 4 is captured as the SYNC reference, giving state TRACK.
REQ-034 In LOCK with WRAP_CNT=3, RST_N pulsed low between edges -> all outputs read 0 before the next edge.
